// File: rtl/sd_stream_ctrl.sv
// Word-level wrapper around an overlapping Mealy 1011 detector.
// Words are scanned MSB-first, and detector history carries across word boundaries.
module sd_stream_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_hits,
   output logic [WIDTH-1:0] out_pos,
   output logic [15:0]      total_hits,
   output logic             det_out,
   output logic             busy,
   output logic [1:0]       state_out
);

   localparam int unsigned TOT_W = 16;
   localparam logic [WIDTH-1:0] SEL_MSB = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [TOT_W-1:0] TOT_MAX = '1;

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, REPORT = 2'd2} ctrl_t;
   typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} det_t;

   ctrl_t            ctrl_q, ctrl_d;
   det_t             det_q, det_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] sel_q, sel_d;
   logic [CNT_W-1:0] hits_q, hits_d;
   logic [WIDTH-1:0] pos_q, pos_d;
   logic [TOT_W-1:0] total_q, total_d;

   det_t det_step_c;
   logic match_c;
   logic bit_c;

   assign bit_c = shift_q[WIDTH-1];

   // Detector transition and Mealy match for the bit at the head of the shift register
   always_comb begin
      det_step_c = det_q;
      match_c    = 1'b0;
      case (det_q)
         D0: det_step_c = bit_c ? D1 : D0;
         D1: det_step_c = bit_c ? D1 : D2;
         D2: det_step_c = bit_c ? D3 : D0;
         D3: begin
            if (bit_c) begin
               match_c    = 1'b1;
               det_step_c = D1;
            end else begin
               det_step_c = D2;
            end
         end
         default: det_step_c = D0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q  <= IDLE;
         det_q   <= D0;
         shift_q <= '0;
         sel_q   <= '0;
         hits_q  <= '0;
         pos_q   <= '0;
         total_q <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         det_q   <= det_d;
         shift_q <= shift_d;
         sel_q   <= sel_d;
         hits_q  <= hits_d;
         pos_q   <= pos_d;
         total_q <= total_d;
      end
   end

   // Control sequencing; sel_q is a one-hot marker of the in_data bit being scanned
   always_comb begin
      ctrl_d  = ctrl_q;
      det_d   = det_q;
      shift_d = shift_q;
      sel_d   = sel_q;
      hits_d  = hits_q;
      pos_d   = pos_q;
      total_d = total_q;
      if (clr) begin
         ctrl_d  = IDLE;
         det_d   = D0;
         hits_d  = '0;
         pos_d   = '0;
         total_d = '0;
      end else begin
         case (ctrl_q)
            IDLE: begin
               if (in_valid) begin
                  shift_d = in_data;
                  sel_d   = SEL_MSB;
                  hits_d  = '0;
                  pos_d   = '0;
                  ctrl_d  = SHIFT;
               end
            end
            SHIFT: begin
               det_d   = det_step_c;
               shift_d = shift_q << 1;
               sel_d   = sel_q >> 1;
               if (match_c) begin
                  pos_d  = pos_q | sel_q;
                  hits_d = hits_q + CNT_W'(1);
                  if (total_q != TOT_MAX)
                     total_d = total_q + TOT_W'(1);
               end
               if (sel_q[0])
                  ctrl_d = REPORT;
            end
            REPORT: begin
               if (out_ready)
                  ctrl_d = IDLE;
            end
            default: ctrl_d = IDLE;
         endcase
      end
   end

   assign in_ready   = (ctrl_q == IDLE);
   assign out_valid  = (ctrl_q == REPORT);
   assign busy       = (ctrl_q == SHIFT) || (ctrl_q == REPORT);
   assign out_hits   = hits_q;
   assign out_pos    = pos_q;
   assign total_hits = total_q;
   assign state_out  = det_q;
   assign det_out    = (ctrl_q == SHIFT) && match_c;

endmodule

// File: tb/tb_sd_stream_ctrl.sv
// Scoreboard bench for sd_stream_ctrl: stimulus queues expected results, a
// negedge monitor compares them on each output handshake.
module tb_sd_stream_ctrl;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clr = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [CNT_W-1:0] out_hits;
   logic [WIDTH-1:0] out_pos;
   logic [15:0]      total_hits;
   logic             det_out;
   logic             busy;
   logic [1:0]       state_out;

   sd_stream_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_hits(out_hits), .out_pos(out_pos), .total_hits(total_hits),
      .det_out(det_out), .busy(busy), .state_out(state_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CNT_W-1:0] hits;
      logic [WIDTH-1:0] pos;
      logic [15:0]      total;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } req_t;

   exp_t exp_q[$];
   req_t req_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic req(input string name, input logic [31:0] act, input logic [31:0] exp);
      req_t r;
      r.name = name;
      r.act  = act;
      r.exp  = exp;
      req_q.push_back(r);
   endtask

   // Single checking process: result scoreboard first, then queued direct checks
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got hits=%0d pos=%h, required no result", out_hits, out_pos);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (out_hits !== e.hits || out_pos !== e.pos || total_hits !== e.total) begin
               errors++;
               $display("FAIL result: got hits=%0d pos=%h total=%0d, required hits=%0d pos=%h total=%0d",
                        out_hits, out_pos, total_hits, e.hits, e.pos, e.total);
            end
         end
      end
      while (req_q.size() > 0) begin
         req_t r;
         r = req_q.pop_front();
         checks++;
         if (r.act !== r.exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", r.name, r.act, r.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send one word; stall = cycles out_ready stays low in REPORT
   task automatic send(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] eh,
                       input logic [WIDTH-1:0] ep, input logic [15:0] et,
                       input logic [1:0] est, input int stall);
      exp_t e;
      int   n;
      e.hits = eh;
      e.pos  = ep;
      e.total = et;
      exp_q.push_back(e);
      req("in_ready_before_send", 32'(in_ready), 32'd1);
      out_ready = (stall == 0);
      in_valid  = 1'b1;
      in_data   = d;
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      req("latency_edges", 32'(n), 32'(WIDTH + 1));
      req("state_in_report", 32'(state_out), 32'(est));
      for (int i = 0; i < stall; i++) begin
         req("stall_out_valid", 32'(out_valid), 32'd1);
         req("stall_hits", 32'(out_hits), 32'(eh));
         req("stall_pos", 32'(out_pos), 32'(ep));
         req("stall_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      req("in_ready_after_consume", 32'(in_ready), 32'd1);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      #2;
      req("rst_in_ready", 32'(in_ready), 32'd1);
      req("rst_out_valid", 32'(out_valid), 32'd0);
      req("rst_total", 32'(total_hits), 32'd0);
      req("rst_state", 32'(state_out), 32'd0);
      req("rst_busy", 32'(busy), 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      send(8'hB0, 4'd1, 8'h10, 16'd1, 2'd0, 0);
      pulse_clr();
      req("clr_total", 32'(total_hits), 32'd0);
      send(8'h5B, 4'd2, 8'h09, 16'd2, 2'd1, 0);
      pulse_clr();
      send(8'hBB, 4'd2, 8'h11, 16'd2, 2'd1, 0);
      pulse_clr();
      send(8'h05, 4'd0, 8'h00, 16'd0, 2'd3, 10);
      send(8'h80, 4'd1, 8'h80, 16'd1, 2'd0, 0);

      // clr beats in_valid in IDLE
      clr = 1'b1;
      in_valid = 1'b1;
      in_data = 8'hBB;
      tick();
      clr = 1'b0;
      in_valid = 1'b0;
      req("clr_wins_busy", 32'(busy), 32'd0);
      req("clr_wins_in_ready", 32'(in_ready), 32'd1);

      // clr mid-SHIFT of 0xBB after its first match
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      req("pre_clr_total", 32'(total_hits), 32'd1);
      pulse_clr();
      req("midclr_in_ready", 32'(in_ready), 32'd1);
      req("midclr_out_valid", 32'(out_valid), 32'd0);
      req("midclr_total", 32'(total_hits), 32'd0);
      req("midclr_state", 32'(state_out), 32'd0);
      repeat (12) tick();
      req("midclr_no_result", 32'(out_valid), 32'd0);

      // asynchronous rst mid-SHIFT of 0xBB
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      req("pre_rst_hits", 32'(out_hits), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      req("arst_in_ready", 32'(in_ready), 32'd1);
      req("arst_out_valid", 32'(out_valid), 32'd0);
      req("arst_hits", 32'(out_hits), 32'd0);
      req("arst_pos", 32'(out_pos), 32'd0);
      req("arst_total", 32'(total_hits), 32'd0);
      req("arst_det_out", 32'(det_out), 32'd0);
      req("arst_busy", 32'(busy), 32'd0);
      req("arst_state", 32'(state_out), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      send(8'hB0, 4'd1, 8'h10, 16'd1, 2'd0, 0);
      req("leftover_expected", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

endmodule

// File: doc/sd_stream_ctrl.md
# sd_stream_ctrl

Word-level controller for the serial 1011 sequence detector. Accepts parallel words over a valid/ready handshake, shifts each word MSB-first through an embedded overlapping Mealy 1011 detector, and returns a per-word result (hit count and hit-position mask) over a second valid/ready handshake. Detector history persists across words, so patterns that span a word boundary are detected. The block sits between a word-oriented producer and consumer and owns the bit sequencing of the detector.

## Interface
- WIDTH, 8: data word width in bits; must be ≥ 2.
- CNT_W, 4: width of the per-word hit count; must satisfy 2^CNT_W > WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear: aborts the current word, clears detector history and total_hits.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  word to scan; bit WIDTH-1 is sent first.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_hits  out  CNT_W  number of matches completed inside the word.
- out_pos  out  WIDTH  bit k set when a match completed on in_data[k].
- total_hits  out  16  saturating count of all matches since reset or clr.
- det_out  out  1  Mealy match pulse for the bit currently being shifted.
- busy  out  1  high in SHIFT or REPORT.
- state_out  out  2  detector state, for debug.

## Operation
- Control FSM states: IDLE, SHIFT, REPORT.
  - IDLE: in_ready=1. When in_valid=1, load in_data into the shift register, clear the bit index, out_hits and out_pos, then go to SHIFT.
  - SHIFT: each cycle presents shift_reg MSB to the detector, shifts left by one, and increments the bit index. After the WIDTH-th bit, go to REPORT.
  - REPORT: out_valid=1. Results hold stable until out_ready=1, then go to IDLE.
- Detector states are the longest suffix that matches a prefix of 1011: D0 "", D1 "1", D2 "10", D3 "101". State encoding is D0=0 to D3=3, shown on state_out.
  - D0: on 1 go to D1; on 0 stay in D0.
  - D1: on 1 stay in D1; on 0 go to D2.
  - D2: on 1 go to D3; on 0 go to D0.
  - D3: on 1 assert det_out and go to D1 (overlap); on 0 go to D2.
- The detector advances only in SHIFT. Its state is held in IDLE and REPORT and carries over to the next word.
- det_out is combinational from the detector state and the current serial bit. It is gated by SHIFT and is 0 otherwise.
- On a match at bit index i (0 = first bit shifted):
  - set out_pos[WIDTH-1-i];
  - increment out_hits;
  - increment total_hits, saturating at 0xFFFF.
- clr takes effect in any state. On the next edge the FSM goes to IDLE, the detector goes to D0, total_hits, out_hits and out_pos go to 0, and out_valid goes to 0. An in-flight word is discarded.
- If clr and in_valid are both high in IDLE, clr wins and the word is not accepted.
- rst has priority over clr.

## Timing
- Reset values:
  - FSM in IDLE, detector in D0;
  - in_ready=1;
  - out_valid=0, out_hits=0, out_pos=0, total_hits=0;
  - det_out=0, busy=0, state_out=0.
- The input handshake completes on the edge where in_valid and in_ready are both 1. SHIFT then runs for exactly WIDTH cycles.
- out_valid rises WIDTH+1 edges after acceptance. The result is consumed on the edge where out_valid and out_ready are both 1.
- in_ready returns 1 on the cycle after consumption. There is no overlap between words, so throughput is one word per WIDTH+2 cycles at best.
- If out_ready is held high, out_valid lasts exactly one cycle. If out_ready is low, the block stalls in REPORT indefinitely and all outputs stay stable.
- total_hits updates on the same edge as the matching bit, so it leads out_valid.
- rst mid-operation: outputs return to their reset values immediately, asynchronously.

## Test plan
- Single match: after reset, send 0xB0 -> out_valid at acceptance+9 edges, out_hits=1, out_pos=0x10, total_hits=1.
- Overlap: after clr, send 0x5B -> out_hits=2, out_pos=0x09.
- Repeated pattern: after clr, send 0xBB -> out_hits=2, out_pos=0x11. This checks the D3 --1--> D1 return.
- Cross-word: after clr, send 0x05 then 0x80.
  - First word: out_hits=0, state_out=3 while in REPORT.
  - Second word: out_hits=1, out_pos=0x80, total_hits=1.
- Backpressure: hold out_ready=0 for 10 cycles during REPORT -> out_valid and results stay stable, in_ready=0. Raise out_ready -> in_ready=1 on the next cycle.
- clr and reset mid-operation:
  - Assert clr during SHIFT of 0xBB -> IDLE on the next edge, no out_valid, total_hits=0, state_out=0.
  - Pulse rst asynchronously -> all outputs return to their reset values immediately.
